// File: rtl/fwrisc_csr_pkg.sv
// +-----------------------------------------------------------------+
// | fwrisc_csr_pkg : shared types and constants for the CSR sequencer |
// | Rev 1.0                                                           |
// +-----------------------------------------------------------------+
`default_nettype none

package fwrisc_csr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CSRW = 3'd2,
    ST_GPRW = 3'd3,
    ST_RSP  = 3'd4
  } csr_state_e;

  typedef enum logic [1:0] {
    OP_ILL = 2'b00,
    OP_RW  = 2'b01,
    OP_RS  = 2'b10,
    OP_RC  = 2'b11
  } csr_op_e;

  localparam logic [4:0] CSR_MSTATUS    = 5'h00;
  localparam logic [4:0] CSR_MTVEC      = 5'h05;
  localparam logic [4:0] CSR_MSCRATCH   = 5'h08;
  localparam logic [4:0] CSR_MEPC       = 5'h09;
  localparam logic [4:0] CSR_MCAUSE     = 5'h0A;
  localparam logic [4:0] CSR_MCYCLE     = 5'h10;
  localparam logic [4:0] CSR_MINSTRET   = 5'h11;
  localparam logic [4:0] CSR_MCYCLEH    = 5'h12;
  localparam logic [4:0] CSR_MINSTRETH  = 5'h13;
  localparam logic [4:0] CSR_SOFT_RESET = 5'h1F;

  function automatic logic is_counter(input logic [4:0] idx);
    return (idx == CSR_MCYCLE) || (idx == CSR_MCYCLEH) ||
           (idx == CSR_MINSTRET) || (idx == CSR_MINSTRETH);
  endfunction

  // Indices 0x14..0x17 hold the machine-information registers.
  function automatic logic is_read_only(input logic [4:0] idx);
    return idx[4:2] == 3'b101;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwrisc_csr_alu.sv
// +-----------------------------------------------------------------+
// | fwrisc_csr_alu : combinational CSR new-value (RW / RS / RC)       |
// | Rev 1.0                                                           |
// +-----------------------------------------------------------------+
`default_nettype none

module fwrisc_csr_alu
  import fwrisc_csr_pkg::*;
(
  input  csr_op_e     op,
  input  logic [31:0] old_val,
  input  logic [31:0] src_val,
  output logic [31:0] new_val
);

  always_comb begin
    new_val = old_val;
    case (op)
      OP_RW:   new_val = src_val;
      OP_RS:   new_val = old_val | src_val;
      OP_RC:   new_val = old_val & ~src_val;
      default: new_val = old_val;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fwrisc_csr_seq.sv
// +-----------------------------------------------------------------+
// | fwrisc_csr_seq : CSR instruction sequencer (read, CSR write, GPR  |
// | write, respond). Option macro: FWRISC_CSR_RO_CHECK_EN            |
// | Rev 1.0                                                           |
// +-----------------------------------------------------------------+
`default_nettype none

module fwrisc_csr_seq
  import fwrisc_csr_pkg::*;
#(
  parameter int ENABLE_COUNTERS = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_csr,
  input  logic [31:0] req_src,
  input  logic        req_src_zero,
  input  logic [4:0]  req_rd,
  output logic [5:0]  rb_raddr,
  input  logic [31:0] rb_rdata,
  output logic [5:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        rd_wen,
  output logic        rsp_valid,
  output logic        rsp_illegal,
  output logic        instr_complete
);

  csr_state_e  state_q, state_d;
  logic        rd_wait_q, rd_wait_d;
  csr_op_e     op_q, op_d;
  logic [4:0]  csr_q, csr_d;
  logic [31:0] src_q, src_d;
  logic        src_zero_q, src_zero_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] old_q, old_d;
  logic [5:0]  rb_raddr_q, rb_raddr_d;

  logic [31:0] new_val;
  logic        op_illegal, wr_attempt, ro_hit, counter_block;
  logic        csr_write_en, gpr_write_en, illegal;

  fwrisc_csr_alu u_alu (
    .op      (op_q),
    .old_val (old_q),
    .src_val (src_q),
    .new_val (new_val)
  );

  always_comb begin
    op_illegal    = (op_q == OP_ILL);
    wr_attempt    = (op_q == OP_RW) || !src_zero_q;
`ifdef FWRISC_CSR_RO_CHECK_EN
    ro_hit        = is_read_only(csr_q) && wr_attempt;
`else
    ro_hit        = 1'b0;
`endif
    counter_block = (ENABLE_COUNTERS == 0) && is_counter(csr_q);
    csr_write_en  = !op_illegal && wr_attempt && !ro_hit && !counter_block;
    gpr_write_en  = !op_illegal && (rd_q != 5'd0);
    illegal       = op_illegal || ro_hit;
  end

  always_comb begin
    state_d        = state_q;
    rd_wait_d      = rd_wait_q;
    op_d           = op_q;
    csr_d          = csr_q;
    src_d          = src_q;
    src_zero_d     = src_zero_q;
    rd_d           = rd_q;
    old_d          = old_q;
    rb_raddr_d     = rb_raddr_q;
    req_ready      = 1'b0;
    rd_waddr       = 6'd0;
    rd_wdata       = 32'd0;
    rd_wen         = 1'b0;
    rsp_valid      = 1'b0;
    rsp_illegal    = 1'b0;
    instr_complete = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d       = csr_op_e'(req_op);
          csr_d      = req_csr;
          src_d      = req_src;
          src_zero_d = req_src_zero;
          rd_d       = req_rd;
          rb_raddr_d = {1'b1, req_csr};
          rd_wait_d  = 1'b1;
          state_d    = ST_RD;
        end
      end
      // First RD cycle lets the regfile register the address; the second captures the data.
      ST_RD: begin
        if (rd_wait_q) begin
          rd_wait_d = 1'b0;
        end else begin
          old_d   = rb_rdata;
          state_d = ST_CSRW;
        end
      end
      ST_CSRW: begin
        rd_waddr = {1'b1, csr_q};
        rd_wdata = new_val;
        rd_wen   = csr_write_en;
        state_d  = ST_GPRW;
      end
      ST_GPRW: begin
        rd_waddr = {1'b0, rd_q};
        rd_wdata = old_q;
        rd_wen   = gpr_write_en;
        state_d  = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid      = 1'b1;
        rsp_illegal    = illegal;
        instr_complete = !illegal;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Suppress the in-flight write and response in the very cycle reset lands.
    if (reset) begin
      req_ready      = 1'b1;
      rd_waddr       = 6'd0;
      rd_wdata       = 32'd0;
      rd_wen         = 1'b0;
      rsp_valid      = 1'b0;
      rsp_illegal    = 1'b0;
      instr_complete = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_wait_q  <= 1'b0;
      op_q       <= OP_ILL;
      csr_q      <= 5'd0;
      src_q      <= 32'd0;
      src_zero_q <= 1'b0;
      rd_q       <= 5'd0;
      old_q      <= 32'd0;
      rb_raddr_q <= 6'd0;
    end else begin
      state_q    <= state_d;
      rd_wait_q  <= rd_wait_d;
      op_q       <= op_d;
      csr_q      <= csr_d;
      src_q      <= src_d;
      src_zero_q <= src_zero_d;
      rd_q       <= rd_d;
      old_q      <= old_d;
      rb_raddr_q <= rb_raddr_d;
    end
  end

  assign rb_raddr = rb_raddr_q;

endmodule

`default_nettype wire

// File: tb/tb_fwrisc_csr_seq.sv
// +-----------------------------------------------------------------+
// | tb_fwrisc_csr_seq : directed bench for fwrisc_csr_seq             |
// | Rev 1.0                                                           |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_fwrisc_csr_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_csr;
  logic [31:0] req_src;
  logic        req_src_zero;
  logic [4:0]  req_rd;
  logic [5:0]  rb_raddr;
  logic [31:0] rb_rdata;
  logic [5:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        rd_wen;
  logic        rsp_valid;
  logic        rsp_illegal;
  logic        instr_complete;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [64];

  // Observations of the last transaction
  int          n_wen, rsp_cnt, rsp_cyc, csr_w_cyc, gpr_w_cyc;
  logic        csr_w, gpr_w, rsp_ill, rsp_ic, ready_busy;
  logic [5:0]  csr_w_addr, gpr_w_addr;
  logic [31:0] csr_w_data, gpr_w_data;

  fwrisc_csr_seq #(.ENABLE_COUNTERS(1)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_csr        (req_csr),
    .req_src        (req_src),
    .req_src_zero   (req_src_zero),
    .req_rd         (req_rd),
    .rb_raddr       (rb_raddr),
    .rb_rdata       (rb_rdata),
    .rd_waddr       (rd_waddr),
    .rd_wdata       (rd_wdata),
    .rd_wen         (rd_wen),
    .rsp_valid      (rsp_valid),
    .rsp_illegal    (rsp_illegal),
    .instr_complete (instr_complete)
  );

  always #5 clock = ~clock;

  // Synchronous-read register file model
  always @(posedge clock) begin
    rb_rdata <= mem[rb_raddr];
    if (rd_wen) mem[rd_waddr] <= rd_wdata;
  end

  task automatic do_req(input logic [1:0] op, input logic [4:0] csr, input logic [31:0] src,
                        input logic sz, input logic [4:0] rd, input bit noise);
    n_wen = 0; rsp_cnt = 0; rsp_cyc = -1; csr_w_cyc = -1; gpr_w_cyc = -1;
    csr_w = 0; gpr_w = 0; rsp_ill = 0; rsp_ic = 0; ready_busy = 0;
    csr_w_addr = '0; gpr_w_addr = '0; csr_w_data = '0; gpr_w_data = '0;
    @(negedge clock);
    req_valid = 1; req_op = op; req_csr = csr; req_src = src; req_src_zero = sz; req_rd = rd;
    @(posedge clock);
    @(negedge clock);
    req_valid = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (cyc <= 5 && req_ready) ready_busy = 1;
      if (rd_wen) begin
        n_wen++;
        if (rd_waddr[5]) begin csr_w = 1; csr_w_addr = rd_waddr; csr_w_data = rd_wdata; csr_w_cyc = cyc; end
        else begin gpr_w = 1; gpr_w_addr = rd_waddr; gpr_w_data = rd_wdata; gpr_w_cyc = cyc; end
      end
      if (rsp_valid) begin
        rsp_cnt++; rsp_cyc = cyc; rsp_ill = rsp_illegal; rsp_ic = instr_complete;
      end
      if (noise && cyc == 2) begin
        req_valid = 1; req_op = 2'b01; req_csr = 5'h0A; req_src = 32'hBAD0BAD0; req_src_zero = 0; req_rd = 5'd9;
      end
      if (noise && cyc == 4) req_valid = 0;
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset = 1; req_valid = 0; req_op = 0; req_csr = 0; req_src = 0; req_src_zero = 0; req_rd = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++; if ({req_ready, rb_raddr} !== {1'b1, 6'd0}) begin miscompares++; $display("FAIL reset_ready_raddr got %b/%h exp 1/00", req_ready, rb_raddr); end
    vectors++; if ({rd_wen, rd_waddr, rd_wdata} !== 39'd0) begin miscompares++; $display("FAIL reset_wport got %b/%h/%h exp 0/00/0", rd_wen, rd_waddr, rd_wdata); end
    vectors++; if ({rsp_valid, rsp_illegal, instr_complete} !== 3'b000) begin miscompares++; $display("FAIL reset_rsp got %b%b%b exp 000", rsp_valid, rsp_illegal, instr_complete); end
    reset = 0;
  endtask

  task automatic test_rw;
    mem[6'h28] = 32'h1234; mem[5] = 32'h0;
    do_req(2'b01, 5'h08, 32'hA5A5A5A5, 1'b0, 5'd5, 0);
    vectors++; if ({csr_w, csr_w_addr, csr_w_data, csr_w_cyc} !== {1'b1, 6'h28, 32'hA5A5A5A5, 32'd3}) begin miscompares++; $display("FAIL rw_csr got %b/%h/%h@%0d exp 1/28/a5a5a5a5@3", csr_w, csr_w_addr, csr_w_data, csr_w_cyc); end
    vectors++; if ({gpr_w, gpr_w_addr, gpr_w_data, gpr_w_cyc} !== {1'b1, 6'h05, 32'h1234, 32'd4}) begin miscompares++; $display("FAIL rw_gpr got %b/%h/%h@%0d exp 1/05/1234@4", gpr_w, gpr_w_addr, gpr_w_data, gpr_w_cyc); end
    vectors++; if ({rsp_cyc, rsp_cnt, rsp_ill, rsp_ic} !== {32'd5, 32'd1, 1'b0, 1'b1}) begin miscompares++; $display("FAIL rw_rsp got cyc%0d cnt%0d ill%b ic%b exp cyc5 cnt1 ill0 ic1", rsp_cyc, rsp_cnt, rsp_ill, rsp_ic); end
    vectors++; if ({mem[6'h28], mem[5], ready_busy} !== {32'hA5A5A5A5, 32'h1234, 1'b0}) begin miscompares++; $display("FAIL rw_mem got %h/%h busy%b exp a5a5a5a5/1234 busy0", mem[6'h28], mem[5], ready_busy); end
  endtask

  task automatic test_rs;
    mem[6'h28] = 32'h0F0F; mem[0] = 32'hDEAD;
    do_req(2'b10, 5'h08, 32'hF000, 1'b0, 5'd0, 0);
    vectors++; if ({csr_w, csr_w_data, n_wen} !== {1'b1, 32'hFF0F, 32'd1}) begin miscompares++; $display("FAIL rs_csr got %b/%h wen%0d exp 1/ff0f wen1", csr_w, csr_w_data, n_wen); end
    vectors++; if ({gpr_w, mem[0], rsp_cyc} !== {1'b0, 32'hDEAD, 32'd5}) begin miscompares++; $display("FAIL rs_nogpr got %b/%h cyc%0d exp 0/dead cyc5", gpr_w, mem[0], rsp_cyc); end
  endtask

  task automatic test_rc;
    mem[6'h28] = 32'hFFFF;
    do_req(2'b11, 5'h08, 32'h0, 1'b1, 5'd3, 0);
    vectors++; if ({csr_w, gpr_w, gpr_w_addr, mem[3], rsp_cyc} !== {1'b0, 1'b1, 6'h03, 32'hFFFF, 32'd5}) begin miscompares++; $display("FAIL rc_zero got csr%b gpr%b/%h x3=%h cyc%0d exp 0 1/03 ffff 5", csr_w, gpr_w, gpr_w_addr, mem[3], rsp_cyc); end
    do_req(2'b11, 5'h08, 32'h00F0, 1'b0, 5'd7, 0);
    vectors++; if ({csr_w_data, mem[6'h28], mem[7]} !== {32'hFF0F, 32'hFF0F, 32'hFFFF}) begin miscompares++; $display("FAIL rc_clear got %h/%h x7=%h exp ff0f/ff0f ffff", csr_w_data, mem[6'h28], mem[7]); end
  endtask

  task automatic test_illegal;
    mem[6'h29] = 32'h77;
    do_req(2'b00, 5'h09, 32'h1, 1'b0, 5'd4, 0);
    vectors++; if ({n_wen, rsp_cyc, rsp_cnt, rsp_ill, rsp_ic} !== {32'd0, 32'd5, 32'd1, 1'b1, 1'b0}) begin miscompares++; $display("FAIL illegal_op got wen%0d cyc%0d cnt%0d ill%b ic%b exp 0 5 1 1 0", n_wen, rsp_cyc, rsp_cnt, rsp_ill, rsp_ic); end
  endtask

  task automatic test_read_only;
    mem[6'h34] = 32'h55; mem[2] = 32'h0;
    do_req(2'b01, 5'h14, 32'h99, 1'b0, 5'd2, 0);
`ifdef FWRISC_CSR_RO_CHECK_EN
    vectors++; if ({csr_w, mem[6'h34], mem[2], rsp_ill, rsp_ic, rsp_cyc} !== {1'b0, 32'h55, 32'h55, 1'b1, 1'b0, 32'd5}) begin miscompares++; $display("FAIL ro_check got csr%b %h x2=%h ill%b ic%b cyc%0d exp 0 55 55 1 0 5", csr_w, mem[6'h34], mem[2], rsp_ill, rsp_ic, rsp_cyc); end
`else
    vectors++; if ({csr_w, mem[6'h34], mem[2], rsp_ill, rsp_ic, rsp_cyc} !== {1'b1, 32'h99, 32'h55, 1'b0, 1'b1, 32'd5}) begin miscompares++; $display("FAIL ro_nocheck got csr%b %h x2=%h ill%b ic%b cyc%0d exp 1 99 55 0 1 5", csr_w, mem[6'h34], mem[2], rsp_ill, rsp_ic, rsp_cyc); end
`endif
  endtask

  task automatic test_special_indices;
    mem[6'h25] = 32'hAAAA; mem[5] = 32'h0;
    do_req(2'b01, 5'h05, 32'h5555, 1'b0, 5'd5, 0);
    vectors++; if ({mem[6'h25], mem[5], n_wen} !== {32'h5555, 32'hAAAA, 32'd2}) begin miscompares++; $display("FAIL same_index got %h x5=%h wen%0d exp 5555 aaaa 2", mem[6'h25], mem[5], n_wen); end
    mem[6'h3F] = 32'h0;
    do_req(2'b10, 5'h1F, 32'h1, 1'b0, 5'd0, 0);
    vectors++; if ({csr_w_addr, mem[6'h3F]} !== {6'h3F, 32'h1}) begin miscompares++; $display("FAIL soft_reset got %h/%h exp 3f/1", csr_w_addr, mem[6'h3F]); end
    mem[6'h30] = 32'h10;
    do_req(2'b01, 5'h10, 32'hC0C0, 1'b0, 5'd0, 0);
    vectors++; if ({csr_w, mem[6'h30], rsp_ic} !== {1'b1, 32'hC0C0, 1'b1}) begin miscompares++; $display("FAIL counter_wr got %b/%h ic%b exp 1/c0c0 ic1", csr_w, mem[6'h30], rsp_ic); end
  endtask

  task automatic test_busy_ignore;
    mem[6'h28] = 32'h1; mem[6'h2A] = 32'h3; mem[9] = 32'h0; mem[6] = 32'h0;
    do_req(2'b10, 5'h08, 32'h2, 1'b0, 5'd6, 1);
    vectors++; if ({mem[6'h28], mem[6], mem[6'h2A], mem[9], rsp_cnt, ready_busy} !== {32'h3, 32'h1, 32'h3, 32'h0, 32'd1, 1'b0}) begin miscompares++; $display("FAIL busy_ignore got %h x6=%h %h x9=%h cnt%0d busy%b exp 3 1 3 0 1 0", mem[6'h28], mem[6], mem[6'h2A], mem[9], rsp_cnt, ready_busy); end
  endtask

  task automatic test_reset_in_csrw;
    int bad_wen = 0;
    int bad_rsp = 0;
    mem[6'h29] = 32'h4242; mem[8] = 32'h0;
    @(negedge clock);
    req_valid = 1; req_op = 2'b01; req_csr = 5'h09; req_src = 32'h9999; req_src_zero = 0; req_rd = 5'd8;
    @(posedge clock);
    @(negedge clock);
    req_valid = 0;
    repeat (2) @(negedge clock);
    reset = 1;
    @(negedge clock);
    vectors++; if ({rd_wen, req_ready} !== 2'b01) begin miscompares++; $display("FAIL rst_csrw_next got wen%b rdy%b exp wen0 rdy1", rd_wen, req_ready); end
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      if (rd_wen) bad_wen++;
      if (rsp_valid) bad_rsp++;
      @(negedge clock);
    end
    vectors++; if ({bad_wen, bad_rsp, mem[6'h29], mem[8]} !== {32'd0, 32'd0, 32'h4242, 32'h0}) begin miscompares++; $display("FAIL rst_csrw_abort got wen%0d rsp%0d %h x8=%h exp 0 0 4242 0", bad_wen, bad_rsp, mem[6'h29], mem[8]); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    test_reset();
    test_rw();
    test_rs();
    test_rc();
    test_illegal();
    test_read_only();
    test_special_indices();
    test_busy_ignore();
    test_reset_in_csrw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fwrisc_csr_seq.md
FWRISC_CSR_SEQ -- requirements
Module: fwrisc_csr_seq

Interface
REQ-001 SHALL have parameter ENABLE_COUNTERS, default 1; 1 = counter CSRs (MCYCLE/MCYCLEH/MINSTRET/MINSTRETH) are writable targets, 0 = writes to them are suppressed.
REQ-002 SHALL have ports: clock  input  1  sole clock, all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 req_valid  input  1  CSR instruction request; req_ready  output  1  high only in IDLE.
REQ-005 req_op  input  2  01=RW, 10=RS (set), 11=RC (clear); 00 is illegal.
REQ-006 req_csr  input  5  CSR index; regfile address is {1'b1, req_csr}.
REQ-007 req_src  input  32  rs1 value or zero-extended zimm; req_src_zero  input  1  source register/zimm field is zero.
REQ-008 req_rd  input  5  destination GPR index.
REQ-009 rb_raddr  output  6  regfile read address; rb_rdata  input  32  regfile data, valid one cycle after address.
REQ-010 rd_waddr  output  6, rd_wdata  output  32, rd_wen  output  1  regfile write port.
REQ-011 rsp_valid  output  1  one-cycle completion pulse; rsp_illegal  output  1  qualified by rsp_valid.
REQ-012 instr_complete  output  1  one-cycle pulse, coincident with rsp_valid when rsp_illegal=0.

Function
REQ-013 SHALL implement FSM states IDLE, RD, CSRW, GPRW, RSP.
REQ-014 IDLE: on req_valid, latch all req_* fields, drive rb_raddr={1'b1,req_csr} from a register, go to RD.
REQ-015 RD: hold rb_raddr one cycle; next cycle capture rb_rdata as old value and go to CSRW.
REQ-016 CSRW: new = RW: src; RS: old|src; RC: old&~src; all 32-bit, no carry; drive rd_waddr={1'b1,csr}, rd_wdata=new, rd_wen=1.
REQ-017 CSRW write SHALL be skipped (rd_wen=0) when op is RS/RC and req_src_zero=1, or target is read-only (REQ-027), or ENABLE_COUNTERS=0 and target is a counter CSR.
REQ-018 GPRW: drive rd_waddr={1'b0,rd}, rd_wdata=old, rd_wen=1; skipped (rd_wen=0) when rd=0.
REQ-019 RSP: rsp_valid=1 for exactly one cycle, then IDLE; accept-to-rsp latency fixed at 5 cycles regardless of skips.
REQ-020 req_op=00: no regfile writes, rsp_illegal=1, instr_complete=0.
REQ-021 rd_wen SHALL never be high outside CSRW/GPRW; at most one write per cycle.
REQ-022 req_csr equal to the soft-reset CSR index is written like any CSR; regfile raises the soft-reset request.
REQ-023 req_valid while not IDLE is ignored; request is held by requester until req_ready.
REQ-024 Write CSR then GPR when rd equals csr low bits: no conflict, distinct address spaces.

Reset
REQ-025 On reset: state=IDLE, req_ready=1, rb_raddr=0, rd_waddr=0, rd_wdata=0, rd_wen=0, rsp_valid=0, rsp_illegal=0, instr_complete=0.
REQ-026 Reset asserted mid-operation SHALL abort with no further write and no rsp_valid, including when asserted during CSRW.

Configuration
REQ-027 Macro FWRISC_CSR_RO_CHECK_EN defined: CSR indices with bits[4:2]=3'b101 are read-only; write attempt (RW, or RS/RC with nonzero src) skips CSRW and sets rsp_illegal=1, GPRW still performed. Undefined: no check, all writes proceed, rsp_illegal only for op 00.

Structure
REQ-028 Package fwrisc_csr_pkg SHALL hold the FSM state enum, op encodings, and CSR index constants.
REQ-029 Sub-module fwrisc_csr_alu (combinational RW/RS/RC new-value computation) SHALL be instantiated once.

Verification
REQ-030 RW csr=MSCRATCH, old=0x1234, src=0xA5A5A5A5, rd=5 -> CSR write 0xA5A5A5A5, x5=0x1234, rsp_valid at cycle 5.
REQ-031 RS old=0x0F0F, src=0xF000, rd=0 -> CSR=0xFF0F, no GPR write.
REQ-032 RC old=0xFFFF, req_src_zero=1, rd=3 -> no CSR write, x3=0xFFFF.
REQ-033 req_op=00 -> zero rd_wen cycles, rsp_illegal=1, instr_complete=0.
REQ-034 With FWRISC_CSR_RO_CHECK_EN, RW to index 0x14 -> no CSR write, GPR written, rsp_illegal=1.
REQ-035 reset pulsed in CSRW cycle -> rd_wen low from next cycle, no rsp_valid, req_ready=1.
